muldiv_sequencer: RTL

Multicycle sequencer for the signed MULT and DIV instructions of the processor datapath. The main control unit hands it two 32-bit operands and a start pulse, then waits in a hold state. The block runs a 32-iteration shift-add multiply or restoring divide and writes the HI/LO result registers. It flags divide-by-zero so the control unit can branch to its exception sequence.

---
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multicycle sequencer for signed MULT / DIV. Runs WIDTH iterations
//            of shift-add multiply or restoring divide on operand magnitudes,
//            then applies signs and writes the HI/LO result registers.
//            Divide-by-zero is flagged without touching HI/LO.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous, active-low reset
//            Start    - request, sampled only while idle
//            Op       - 0 = MULT, 1 = DIV
//            A, B     - signed operands (rs, rt)
//            Busy     - high while iterating or fixing signs
//            Done     - one-cycle pulse, Hi/Lo valid from this cycle
//            DivZero  - one-cycle pulse on DIV with B == 0
//            Hi, Lo   - MULT upper/lower product, DIV remainder/quotient
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int               c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_DZ   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;

    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_op;
    logic                 r_sa;
    logic                 r_sb;
    // Fixed operand: multiplicand |A| for MULT, divisor |B| for DIV.
    logic [WIDTH-1:0]     r_opnd;
    // MULT: {partial product high, remaining multiplier bits}.
    // DIV : {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod_signed;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_hi_fix;
    logic [WIDTH-1:0]     w_lo_fix;

    // ------------------------------------------------------------------
    // State register and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            Busy    <= (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
            Done    <= (w_state_nxt == S_DONE);
            DivZero <= (w_state_nxt == S_DZ);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (Op && (B == '0)) begin
                        w_state_nxt = S_DZ;
                    end else begin
                        w_state_nxt = S_CALC;
                        w_accept    = 1'b1;
                    end
                end
            end
            S_CALC:  if (r_cnt == c_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            S_DZ:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_mag_a = A[WIDTH-1] ? (-A) : A;
    assign w_mag_b = B[WIDTH-1] ? (-B) : B;

    // Add-then-shift-right; the carry out of the add becomes the new MSB.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the remainder stays below the divisor, so the
    // shifted value fits in WIDTH+1 bits and the restore path fits in WIDTH.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_step  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_signed = (r_sa ^ r_sb) ? (-r_acc) : r_acc;
    assign w_rem         = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot        = r_acc[WIDTH-1:0];

    // Quotient truncates toward zero; remainder follows the dividend sign.
    // The most-negative / -1 case wraps back to the most-negative value.
    assign w_hi_fix = r_op ? (r_sa ? (-w_rem) : w_rem)
                           : w_prod_signed[2*WIDTH-1:WIDTH];
    assign w_lo_fix = r_op ? ((r_sa ^ r_sb) ? (-w_quot) : w_quot)
                           : w_prod_signed[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_op   <= 1'b0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_opnd <= '0;
            r_acc  <= '0;
            Hi     <= '0;
            Lo     <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op   <= Op;
            r_sa   <= A[WIDTH-1];
            r_sb   <= B[WIDTH-1];
            r_opnd <= Op ? w_mag_b : w_mag_a;
            r_acc  <= {{WIDTH{1'b0}}, (Op ? w_mag_a : w_mag_b)};
        end else if (r_state == S_CALC) begin
            r_cnt  <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            r_acc  <= r_op ? w_div_step : w_mul_step;
        end else if (r_state == S_FIX) begin
            Hi     <= w_hi_fix;
            Lo     <= w_lo_fix;
        end
    end

endmodule
`default_nettype wire
